// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive deserializer.
// The FSM state encoding, byte width and start-sample divisor live here.
package uart_rx_pkg;

  localparam int DATA_W    = 8;
  localparam int START_DIV = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small power-of-two receive FIFO with combinational head read, occupancy count
// and a synchronous flush that overrides push and pop.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     level_q;
  logic               do_push, do_pop;

  assign empty_o   = (level_q == '0);
  assign full_o    = (level_q == (PTR_W+1)'(DEPTH));
  assign level_o   = level_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A full FIFO can still accept a byte when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: the storage is reset because the head is visible on rd_data_o and
  // must read 0 out of reset; a non-reset RAM would expose X here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !clr_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (PTR_W+1)'(1);
        2'b01:   level_q <= level_q - (PTR_W+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: synchronizes rx_i, samples mid-bit with a reloadable
// down-counter and pushes completed bytes into a small receive FIFO.
module uart_rx_deser
  import uart_rx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CPB_W = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic [CPB_W-1:0]        clks_per_bit_i,
  input  logic                    rx_i,
  output logic [DATA_W-1:0]       rd_data_o,
  output logic                    rd_valid_o,
  input  logic                    rd_ready_i,
  input  logic                    fifo_clr_i,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    frame_err_o,
  output logic                    overflow_o,
  output logic                    intr_rx_o
);

  localparam int IDX_W = $clog2(DATA_W);

  logic              rx_meta_q, rxs_q, rxs_prev_q;
  rx_state_e         state_q, state_d;
  logic [CPB_W-1:0]  cpb_q, cpb_d, cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              sample, start_edge;
  logic              push_req, frame_err_d;
  logic              frame_err_q, overflow_q;
  logic              pop, fifo_empty, fifo_full;

  // rx_i is asynchronous; rxs_prev_q is only for falling-edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx_i;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  assign start_edge = rxs_prev_q && !rxs_q;
  assign sample     = (cnt_q == '0);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    cpb_d       = cpb_q;
    push_req    = 1'b0;
    frame_err_d = 1'b0;

    if (state_q != ST_IDLE) begin
      cnt_d = sample ? (cpb_q - CPB_W'(1)) : (cnt_q - CPB_W'(1));
    end

    case (state_q)
      ST_IDLE: begin
        if (en_i && start_edge) begin
          cpb_d   = clks_per_bit_i;
          cnt_d   = (clks_per_bit_i / CPB_W'(START_DIV)) - CPB_W'(1);
          idx_d   = '0;
          shift_d = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (sample) begin
          idx_d   = '0;
          state_d = rxs_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (sample) begin
          shift_d[idx_q] = rxs_q;
          if (idx_q == IDX_W'(DATA_W - 1)) state_d = ST_STOP;
          else                             idx_d   = idx_q + IDX_W'(1);
        end
      end
      ST_STOP: begin
        if (sample) begin
          push_req    = rxs_q;
          frame_err_d = !rxs_q;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Disabling abandons any partial frame; queued bytes stay in the FIFO.
    if (!en_i) begin
      state_d     = ST_IDLE;
      push_req    = 1'b0;
      frame_err_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      cpb_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      cpb_q       <= cpb_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= push_req && fifo_full && !pop && !fifo_clr_i;
    end
  end

  assign pop = rd_valid_o && rd_ready_i;

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (fifo_clr_i),
    .push_i    (push_req),
    .wr_data_i (shift_q),
    .pop_i     (pop),
    .rd_data_o (rd_data_o),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .level_o   (level_o)
  );

  assign rd_valid_o  = !fifo_empty;
  assign intr_rx_o   = rd_valid_o;
  assign frame_err_o = frame_err_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser: fixed frame table, directed corner
// sequences and randomized frames against a queue-based FIFO model.
module tb_uart_rx_deser;

  localparam int DEPTH = 4;
  localparam int CPB_W = 16;

  logic                   clk = 1'b0;
  logic                   rst_ni = 1'b0;
  logic                   en_i = 1'b1;
  logic [CPB_W-1:0]       clks_per_bit_i = 16'd16;
  logic                   rx_i = 1'b1;
  logic                   rd_ready_i = 1'b0;
  logic                   fifo_clr_i = 1'b0;
  logic [7:0]             rd_data_o;
  logic                   rd_valid_o;
  logic [$clog2(DEPTH):0] level_o;
  logic                   frame_err_o, overflow_o, intr_rx_o;

  uart_rx_deser #(.DEPTH(DEPTH), .CPB_W(CPB_W)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .en_i           (en_i),
    .clks_per_bit_i (clks_per_bit_i),
    .rx_i           (rx_i),
    .rd_data_o      (rd_data_o),
    .rd_valid_o     (rd_valid_o),
    .rd_ready_i     (rd_ready_i),
    .fifo_clr_i     (fifo_clr_i),
    .level_o        (level_o),
    .frame_err_o    (frame_err_o),
    .overflow_o     (overflow_o),
    .intr_rx_o      (intr_rx_o)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   ferr_cnt = 0, ovf_cnt = 0, valid_rise_cyc = 0, t_start = 0;
  logic valid_prev = 1'b0;
  int   n_checks = 0, n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters observed away from the active edge.
  always @(negedge clk) begin
    if (frame_err_o) ferr_cnt++;
    if (overflow_o)  ovf_cnt++;
    if (rd_valid_o && !valid_prev) valid_rise_cyc = cyc;
    valid_prev = rd_valid_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_bit(input logic b, input int cpb);
    rx_i = b;
    repeat (cpb) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame; the start bit begins just after a rising edge.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int cpb);
    clks_per_bit_i = 16'(cpb);
    @(posedge clk);
    #1;
    t_start = cyc;
    drive_bit(1'b0, cpb);
    for (int i = 0; i < 8; i++) drive_bit(d[i], cpb);
    drive_bit(stop, cpb);
    rx_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic pop_expect(input logic [7:0] exp);
    @(negedge clk);
    check("pop_valid", rd_valid_o, 1);
    check("pop_data", rd_data_o, exp);
    rd_ready_i = 1'b1;
    @(posedge clk);
    #1;
    rd_ready_i = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         cpb;
    logic       pop_after;
    int         exp_level;
    int         exp_ferr;
    logic [7:0] exp_head;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] model_q[$];

  initial begin
    int f0, o0, lat, pe, npop;
    logic [7:0] d;
    logic       stop;
    int         cpb;

    vecs[0] = '{8'hA5, 1'b1, 16, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 16, 1'b0, 0, 1, 8'h00};
    vecs[2] = '{8'h55, 1'b1, 16, 1'b1, 1, 0, 8'h55};
    vecs[3] = '{8'h00, 1'b1,  8, 1'b0, 1, 0, 8'h00};
    vecs[4] = '{8'hFF, 1'b1,  6, 1'b1, 2, 0, 8'h00};
    vecs[5] = '{8'h81, 1'b1, 23, 1'b0, 2, 0, 8'hFF};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", rd_valid_o, 0);
    check("rst_level", level_o, 0);
    check("rst_data", rd_data_o, 0);
    check("rst_ferr", frame_err_o, 0);
    check("rst_ovf", overflow_o, 0);
    check("rst_intr", intr_rx_o, 0);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    repeat (4) @(posedge clk);

    // Frame table
    o0 = ovf_cnt;
    for (int i = 0; i < 6; i++) begin
      f0 = ferr_cnt;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].cpb);
      @(negedge clk);
      if (i == 0) begin
        lat = valid_rise_cyc - t_start;
        if (!(lat >= 153 && lat <= 156)) $display("latency measured %0d cycles", lat);
        check("latency_window", (lat >= 153 && lat <= 156), 1);
      end
      check("vec_level", level_o, vecs[i].exp_level);
      check("vec_ferr", ferr_cnt - f0, vecs[i].exp_ferr);
      check("vec_intr", intr_rx_o, vecs[i].exp_level != 0);
      if (vecs[i].exp_level != 0) check("vec_head", rd_data_o, vecs[i].exp_head);
      if (vecs[i].pop_after) pop_expect(vecs[i].exp_head);
    end
    check("vec_no_ovf", ovf_cnt - o0, 0);

    // Flush
    @(posedge clk); #1 fifo_clr_i = 1'b1;
    @(posedge clk); #1 fifo_clr_i = 1'b0;
    @(negedge clk);
    check("clr_level", level_o, 0);
    check("clr_valid", rd_valid_o, 0);

    // Overflow at the fifth byte
    o0 = ovf_cnt;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 16);
    @(negedge clk);
    check("full_level", level_o, 4);
    send_frame(8'h05, 1'b1, 16);
    @(negedge clk);
    check("ovf_pulse", ovf_cnt - o0, 1);
    check("ovf_level", level_o, 4);
    for (int i = 1; i <= 4; i++) pop_expect(8'(i));
    @(negedge clk);
    check("drain_valid", rd_valid_o, 0);
    rd_ready_i = 1'b1;
    @(posedge clk); #1 rd_ready_i = 1'b0;
    @(negedge clk);
    check("empty_pop_level", level_o, 0);

    // Push and pop together while full
    send_frame(8'h11, 1'b1, 16);
    send_frame(8'h22, 1'b1, 16);
    send_frame(8'h33, 1'b1, 16);
    send_frame(8'h44, 1'b1, 16);
    o0 = ovf_cnt;
    pe = 3 + 16 / 2 + 9 * 16;
    fork
      send_frame(8'h66, 1'b1, 16);
      begin
        repeat (pe) @(posedge clk);
        #1 rd_ready_i = 1'b1;
        @(posedge clk);
        #1 rd_ready_i = 1'b0;
      end
    join
    @(negedge clk);
    check("pushpop_level", level_o, 4);
    check("pushpop_no_ovf", ovf_cnt - o0, 0);
    pop_expect(8'h22);
    pop_expect(8'h33);
    pop_expect(8'h44);
    pop_expect(8'h66);

    // Clear wins over a simultaneous push
    send_frame(8'h01, 1'b1, 16);
    o0 = ovf_cnt;
    fork
      send_frame(8'h02, 1'b1, 16);
      begin
        repeat (pe) @(posedge clk);
        #1 fifo_clr_i = 1'b1;
        @(posedge clk);
        #1 fifo_clr_i = 1'b0;
      end
    join
    @(negedge clk);
    check("clrpush_level", level_o, 0);
    check("clrpush_no_ovf", ovf_cnt - o0, 0);

    // Short low glitch is rejected at the start sample
    f0 = ferr_cnt;
    clks_per_bit_i = 16'd16;
    @(posedge clk); #1 rx_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_i = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("glitch_level", level_o, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);

    // Enable dropped mid-data
    fork
      send_frame(8'h99, 1'b1, 16);
      begin
        repeat (60) @(posedge clk);
        #1 en_i = 1'b0;
      end
    join
    en_i = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("endrop_level", level_o, 0);
    check("endrop_ferr", ferr_cnt - f0, 0);
    send_frame(8'h7E, 1'b1, 16);
    @(negedge clk);
    check("endrop_next_level", level_o, 1);
    pop_expect(8'h7E);

    // Reset asserted mid-data, with a byte already queued
    send_frame(8'h42, 1'b1, 16);
    fork
      send_frame(8'hC3, 1'b1, 16);
      begin
        repeat (60) @(posedge clk);
        #1 rst_ni = 1'b0;
      end
    join
    @(negedge clk);
    check("rstmid_level", level_o, 0);
    check("rstmid_valid", rd_valid_o, 0);
    @(posedge clk); #1 rst_ni = 1'b1;
    repeat (4) @(posedge clk);
    send_frame(8'h7E, 1'b1, 16);
    @(negedge clk);
    check("rstmid_next_level", level_o, 1);
    pop_expect(8'h7E);

    // Randomized frames against the queue model
    model_q.delete();
    for (int it = 0; it < 16; it++) begin
      int exp_f, exp_o;
      d     = 8'($urandom);
      cpb   = $urandom_range(6, 20);
      stop  = ($urandom_range(0, 7) != 0);
      exp_f = 0;
      exp_o = 0;
      if (!stop)                       exp_f = 1;
      else if (model_q.size() < DEPTH) model_q.push_back(d);
      else                             exp_o = 1;
      f0 = ferr_cnt;
      o0 = ovf_cnt;
      send_frame(d, stop, cpb);
      @(negedge clk);
      check("rnd_level", level_o, model_q.size());
      check("rnd_ferr", ferr_cnt - f0, exp_f);
      check("rnd_ovf", ovf_cnt - o0, exp_o);
      npop = $urandom_range(0, model_q.size());
      repeat (npop) pop_expect(model_q.pop_front());
    end
    while (model_q.size() > 0) pop_expect(model_q.pop_front());
    @(negedge clk);
    check("rnd_final_valid", rd_valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
